// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller.
// Detects load-use hazards between the instruction in ID/EX and the one in IF/ID.
// On a hazard it holds the PC and IF/ID and inserts bubbles into ID/EX.
// A taken branch resolved in MEM flushes the three younger stages and takes
// priority over any stall.
// Saturating counters record stall cycles and branch-flush events.
module hazard_stall_unit #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_RegRs,
   input  logic [4:0]       ID_RegRt,
   input  logic             ID_UsesRt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_WriteReg,
   input  logic             MEM_PCSrc,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Flush,
   output logic             Stalling,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic {RUN, LDSTALL} state_t;

   // Bubbles still owed after the detecting cycle, loaded on entry to LDSTALL
   localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

   state_t     state;
   logic [2:0] cnt;
   logic       hazard;

   // Register $0 is hard-wired to zero, so a write to it can never feed a later read
   assign hazard = EX_MemRead && (EX_WriteReg != 5'd0) &&
                   ((EX_WriteReg == ID_RegRs) ||
                    (ID_UsesRt && (EX_WriteReg == ID_RegRt)));

   assign Stalling = (state == LDSTALL);

   // Pipeline controls: a taken branch overrides stalls, and the hazard input is ignored while in LDSTALL
   always_comb begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Flush = 1'b0;
      if (MEM_PCSrc) begin
         IF_ID_Flush  = 1'b1;
         ID_EX_Flush  = 1'b1;
         EX_MEM_Flush = 1'b1;
      end else if ((state == LDSTALL) || hazard) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
      end
   end

   // Stall sequencer: the detecting cycle is the first bubble, and LDSTALL counts down the remaining bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         case (state)
            RUN: begin
               if (!MEM_PCSrc && hazard && (LOAD_STALL_CYCLES > 1)) begin
                  state <= LDSTALL;
                  cnt   <= STALL_RELOAD;
               end
            end
            LDSTALL: begin
               if (MEM_PCSrc) begin
                  state <= RUN;
                  cnt   <= 3'd0;
               end else begin
                  cnt <= cnt - 3'd1;
                  if (cnt == 3'd1) begin
                     state <= RUN;
                  end
               end
            end
            default: begin
               state <= RUN;
               cnt   <= 3'd0;
            end
         endcase
      end
   end

   // Event counters stop at all-ones so that a long run cannot wrap back to a small value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (!PCWrite && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
         end
         if (MEM_PCSrc && (FlushCount != '1)) begin
            FlushCount <= FlushCount + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller that consumes the ID/EX and EX/MEM pipeline-register outputs plus the IF/ID instruction fields, and drives the stall/bubble/flush controls back into the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards by holding PC and IF/ID while inserting bubbles into ID/EX. It flushes the three younger stages when a taken branch resolves in MEM. Saturating event counters support SAD-kernel performance checks.

## Interface
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..4.
- CNT_W, 16: width of the stall-cycle and flush-event counters.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_RegRs  in  5  rs field of the instruction in IF/ID.
- ID_RegRt  in  5  rt field of the instruction in IF/ID.
- ID_UsesRt  in  1  instruction in IF/ID reads rt as a source (R-type, branch, store).
- EX_MemRead  in  1  MemRead_out of ID/EX.
- EX_WriteReg  in  5  destination register of the ID/EX instruction, after the RegDst mux.
- MEM_PCSrc  in  1  taken-branch signal resolved in EX/MEM.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  zero the IF/ID instruction on the next edge.
- ID_EX_Flush  out  1  load zeros into all ID/EX control fields on the next edge (bubble).
- EX_MEM_Flush  out  1  zero the EX/MEM control fields on the next edge.
- Stalling  out  1  FSM is in LDSTALL (registered state).
- StallCount  out  CNT_W  total stall cycles, saturating.
- FlushCount  out  CNT_W  total branch-flush events, saturating.

## Operation
- hazard = EX_MemRead & (EX_WriteReg != 0) & ((EX_WriteReg == ID_RegRs) | (ID_UsesRt & EX_WriteReg == ID_RegRt)).
- The FSM has two states, RUN and LDSTALL. There is a 3-bit down-counter `cnt`.
- RUN, MEM_PCSrc=1:
  - IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush are 1.
  - PCWrite and IF_ID_Write are 1.
  - The FSM stays in RUN.
  - The branch takes priority over hazard.
- RUN, hazard=1, no branch:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
  - If LOAD_STALL_CYCLES>1, go to LDSTALL with cnt=LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- RUN, idle (no branch, no hazard):
  - PCWrite=1, IF_ID_Write=1.
  - All flushes are 0.
- LDSTALL, no branch:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
  - cnt decrements.
  - When cnt==1, the next state is RUN.
  - hazard is ignored in this state.
- LDSTALL, MEM_PCSrc=1:
  - Outputs are the same as the RUN branch case.
  - The next state is RUN and cnt is cleared, which aborts the stall.
- StallCount increments by 1 on every edge where PCWrite=0.
- FlushCount increments by 1 on every edge where MEM_PCSrc=1.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Register $0 never creates a hazard.

## Timing
- Control outputs are combinational from the inputs and the registered state/cnt. They are valid in the same cycle as the detecting condition.
- A load in EX at cycle N with a dependent instruction in ID produces:
  - stall controls during cycles N .. N+LOAD_STALL_CYCLES-1;
  - the dependent instruction enters EX at N+LOAD_STALL_CYCLES+1.
- A taken branch in MEM at cycle M flushes for exactly cycle M. The target is fetched at M+1.
- Reset values:
  - state=RUN, cnt=0, Stalling=0.
  - StallCount=0, FlushCount=0.
  - With inputs at 0: PCWrite=1, IF_ID_Write=1, all flushes 0.
- Reset asserted mid-stall returns to RUN immediately (asynchronously). Counters clear.
- Back-to-back loads: a second hazard detected in the first RUN cycle after a stall starts a new stall sequence.

## Test plan
- Load-use on rs, LOAD_STALL_CYCLES=1: EX_MemRead=1, EX_WriteReg=5, ID_RegRs=5 for one cycle.
  - Expect PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly 1 cycle.
  - Expect StallCount=1.
- rt dependency gating: EX_WriteReg=7, ID_RegRt=7.
  - With ID_UsesRt=0, expect no stall.
  - With ID_UsesRt=1, expect a stall.
  - With EX_WriteReg=0 and matching fields, expect never a stall.
- Multi-cycle stall, LOAD_STALL_CYCLES=3: a hazard pulse at cycle N.
  - Expect stall controls for cycles N..N+2 with Stalling=1 at N+1 and N+2.
  - Expect RUN at N+3 and StallCount=3.
- Branch during stall, LOAD_STALL_CYCLES=3: MEM_PCSrc=1 at N+1.
  - Expect all three flushes=1 and PCWrite=1 at N+1.
  - Expect RUN at N+2, StallCount=1, FlushCount=1.
- Branch and hazard in the same cycle: expect flushes=1, PCWrite=1, no stall, StallCount unchanged.
- Reset and saturation:
  - Assert rst mid-stall: expect RUN, PCWrite=1 and counters=0 without waiting for a clock edge.
  - With CNT_W=4, hold a hazard for 20 stall cycles: expect StallCount to stay at 15.
